// File: rtl/counter_pkg.sv
// Shared constants and helpers for the generic up/down event/timer counter.
package counter_pkg;
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Prescaler counter width; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that ends a period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);
  localparam int PW = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  // With PRESCALE=1 r_cnt never leaves 0, so tick reduces to en.
  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)           r_cnt <= '0;
    else if (sync_clr) r_cnt <= '0;
    else if (tick)     r_cnt <= '0;
    else if (en)       r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mod_updown_counter.sv
// WIDTH-bit up/down counter with modulus, parallel load, prescaler and
// wrap/saturate mode; tc pulses on wrap for cascading.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1,
  parameter bit     SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             sat
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam bit FULL   = (MODULUS == (longint'(1) << WIDTH));
  localparam bit IS_SAT = (SATURATE == MODE_SAT);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_cfg
      $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH, WIDTH in 1..32");
    end
  endgenerate

  logic             w_tick;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_ld_val;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .sync_clr (ld),
    .tick     (w_tick)
  );

  assign w_at_max  = (q == MAXV);
  assign w_at_zero = (q == '0);
  assign sat       = up ? w_at_max : w_at_zero;
  assign w_ld_val  = (d > MAXV) ? MAXV : d;

  // Full-range modulus wraps through plain overflow in both directions.
  always_comb begin
    w_q_nxt = q;
    w_wrap  = 1'b0;
    if (up) begin
      w_q_nxt = (w_at_max && !FULL) ? '0 : q + 1'b1;
      w_wrap  = w_at_max;
    end else begin
      w_q_nxt = w_at_zero ? MAXV : q - 1'b1;
      w_wrap  = w_at_zero;
    end
    if (IS_SAT && w_wrap) begin
      w_q_nxt = q;
      w_wrap  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (ld) begin
      q  <= w_ld_val;
      tc <= 1'b0;
    end else if (w_tick) begin
      q  <= w_q_nxt;
      tc <= w_wrap;
    end else begin
      tc <= 1'b0;
    end
  end
endmodule
